// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: program counter and dual-slot IF/ID register with stall and branch-redirect control
module fetch_ifid_stage #(
    parameter int PC_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [PC_W-1:0]  IF_ID_pc,
    output logic [15:0]      IF_ID_inst1,
    output logic [15:0]      IF_ID_inst2,
    output logic             IF_ID_valid1,
    output logic             IF_ID_valid2,
    output logic [2:0]       IF_ID_inst1_Rm,
    output logic [2:0]       IF_ID_inst1_Rn,
    output logic [2:0]       IF_ID_inst1_Rd,
    output logic [2:0]       IF_ID_inst2_Rm,
    output logic [2:0]       IF_ID_inst2_Rn,
    output logic [2:0]       IF_ID_inst2_Rd,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
    state_t state, state_next;
    logic [PC_W-1:0] pc, pc_seq;
    logic redirect, stall, misalign;
    logic [15:0] slot1, slot2;

    assign imem_addr = {pc[PC_W-1:2], 2'b00};
    assign pc_seq    = imem_addr + PC_W'(4);
    assign redirect  = branch_taken & PCWrite;
    assign stall     = ~IF_ID_Write & ~redirect;
    assign misalign  = pc[1];
    assign slot1     = misalign ? imem_rdata[31:16] : imem_rdata[15:0];
    assign slot2     = misalign ? 16'h0000 : imem_rdata[31:16];

    assign IF_ID_inst1_Rm = IF_ID_inst1[8:6];
    assign IF_ID_inst1_Rn = IF_ID_inst1[5:3];
    assign IF_ID_inst1_Rd = IF_ID_inst1[2:0];
    assign IF_ID_inst2_Rm = IF_ID_inst2[8:6];
    assign IF_ID_inst2_Rn = IF_ID_inst2[5:3];
    assign IF_ID_inst2_Rd = IF_ID_inst2[2:0];

    // PC: redirect wins over sequential advance; both gated by PCWrite
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else if (redirect)
            pc <= branch_target & ~PC_W'(1);
        else if (PCWrite)
            pc <= pc_seq;
    end

    // IF/ID: a redirect squashes both slots, otherwise load when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_pc     <= '0;
            IF_ID_inst1  <= '0;
            IF_ID_inst2  <= '0;
            IF_ID_valid1 <= 1'b0;
            IF_ID_valid2 <= 1'b0;
        end else if (redirect) begin
            IF_ID_inst1  <= '0;
            IF_ID_inst2  <= '0;
            IF_ID_valid1 <= 1'b0;
            IF_ID_valid2 <= 1'b0;
        end else if (IF_ID_Write) begin
            IF_ID_pc     <= pc;
            IF_ID_inst1  <= slot1;
            IF_ID_inst2  <= slot2;
            IF_ID_valid1 <= 1'b1;
            IF_ID_valid2 <= ~misalign;
        end
    end

    // saturating count of cycles where IF/ID was held without a redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

    // fetch state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_next;
    end

    // next state: any non-redirect hold enters STALL, a load or redirect leaves it
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = stall ? STALL : RUN;
            RUN:     state_next = stall ? STALL : RUN;
            STALL:   state_next = (IF_ID_Write || redirect) ? RUN : STALL;
            default: state_next = BOOT;
        endcase
    end
endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Program counter and IF/ID pipeline register for the dual-slot pipeline.
- Each cycle it fetches one 32-bit word holding two 16-bit instructions.
- It latches them into IF/ID with per-slot valid bits and drives the decoded Rm/Rn/Rd fields that the hazard detection unit compares.
- It consumes that unit's PCWrite/IF_ID_Write stall controls and the decode-stage branch redirect.

Parameters:
- PC_W, 16: PC and address width in bits. Bytes are addressed; bit 0 is always 0.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- PCWrite, input, 1: 1 = PC may update this cycle.
- IF_ID_Write, input, 1: 1 = IF/ID may load this cycle.
- branch_taken, input, 1: taken-branch redirect from decode.
- branch_target, input, PC_W: redirect byte address (halfword aligned).
- imem_addr, output, PC_W: word-aligned fetch address to the combinational instruction memory.
- imem_rdata, input, 32: fetched word. [15:0] is the lower halfword, [31:16] the upper.
- IF_ID_pc, output, PC_W: PC of the latched fetch.
- IF_ID_inst1, output, 16: slot-1 instruction.
- IF_ID_inst2, output, 16: slot-2 instruction.
- IF_ID_valid1, output, 1: slot-1 valid.
- IF_ID_valid2, output, 1: slot-2 valid.
- IF_ID_inst1_Rm, output, 3: IF_ID_inst1[8:6].
- IF_ID_inst1_Rn, output, 3: IF_ID_inst1[5:3].
- IF_ID_inst1_Rd, output, 3: IF_ID_inst1[2:0].
- IF_ID_inst2_Rm, output, 3: IF_ID_inst2[8:6].
- IF_ID_inst2_Rn, output, 3: IF_ID_inst2[5:3].
- IF_ID_inst2_Rd, output, 3: IF_ID_inst2[2:0].
- stall_count, output, CNT_W: saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - PC=RESET_PC.
  - IF_ID_pc=0, inst1=inst2=0, valid1=valid2=0.
  - stall_count=0, state=BOOT.
- imem_addr = {PC[PC_W-1:2],2'b00}, combinational. Memory read is zero-latency; the data is latched at the next edge.
- misalign = PC[1]. When misalign=1, the target instruction sits in the upper halfword.
- Slot selection:
  - Aligned: inst1=rdata[15:0], inst2=rdata[31:16], valid1=1, valid2=1.
  - Misaligned: inst1=rdata[31:16], inst2=0, valid1=1, valid2=0.
- Sequential next PC = {PC[PC_W-1:2],2'b00}+4, modulo 2^PC_W. It wraps from all-ones word to 0.
- Field outputs are pure combinational slices of the IF/ID registers, so they are zero when a slot is squashed.
- Edge priority, highest first:
  - reset.
  - Redirect (branch_taken=1 and PCWrite=1): PC<=branch_target with bit 0 forced to 0. IF/ID loads a bubble (valid1=valid2=0, insts=0) regardless of IF_ID_Write. Penalty is 1 cycle.
  - branch_taken=1 with PCWrite=0 is ignored. The stalled branch re-resolves later.
  - Normal: if PCWrite=1, PC<=next PC. If IF_ID_Write=1, IF/ID<=fetched slots and IF_ID_pc<=PC. Each enable is honoured independently; when an enable is low its register holds.
- State machine:
  - BOOT: first cycle after reset. IF/ID is invalid and fetch proceeds normally. Go to RUN at the next edge. If IF_ID_Write=0, go to STALL instead.
  - RUN: on IF_ID_Write=0 (and no redirect), go to STALL.
  - STALL: IF/ID holds. Return to RUN on the first edge with IF_ID_Write=1 or a redirect.
- stall_count:
  - Increments at each edge with IF_ID_Write=0 and no redirect, in any state except during reset.
  - Saturates at 2^CNT_W-1 and never wraps.
- Stall then release: the instruction held in IF/ID is the one presented to decode once the stall clears. No fetch is lost or duplicated because PC also held.
- Redirect target with bit1=1: the first fetch after the redirect is misaligned (valid2=0). The next PC is aligned.

Test Plan:
- Reset, then free-run with imem word = {16'hB2C3,16'hA1D4} at every address:
  - Cycle 1 after reset: valid=00, imem_addr=0.
  - Cycle 2: IF_ID_pc=0, inst1=A1D4, inst2=B2C3, inst1_Rd=4, inst1_Rn=2, inst1_Rm=7.
  - Cycle 3: IF_ID_pc=4.
- Hold PCWrite=IF_ID_Write=0 for 3 cycles at PC=8:
  - IF/ID and PC are frozen.
  - stall_count increments 0→3.
  - Release: next IF_ID_pc=8, then 0x0C.
- branch_taken=1, target=0x0020, PCWrite=1:
  - Next edge: valid=00, imem_addr=0x20.
  - Following edge: IF_ID_pc=0x20, valid=11.
- branch_taken=1, target=0x0032:
  - Fetch at word 0x30: inst1=rdata[31:16], valid2=0.
  - Next PC=0x34, aligned, valid=11.
- branch_taken=1 with PCWrite=0 and IF_ID_Write=0: PC, IF/ID and the bubble are unchanged, and stall_count increments.
- CNT_W=2, 5 stall cycles: stall_count is 1,2,3,3,3. Assert reset mid-stall: all outputs return to their reset values immediately.
